// File: rtl/spi_subunit_sync.sv
// SPI peripheral that oversamples SCLK/CS/MOSI in the system clock domain.
// Supports all four SPI modes, any word width, and back-to-back words per CS frame.
module spi_subunit_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic SclkIdle = (CPOL != 0);
  localparam logic [CW-1:0] LastBit = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state_q;
  logic [SYNC_STAGES-1:0]  sclkSync_q, csSync_q, mosiSync_q;
  logic                    sclkPrev_q, csPrev_q;
  logic [CW-1:0]           bitCnt_q;
  logic [DATA_WIDTH-1:0]   txBuf_q, txShift_q, rxShift_q, rxData_q;
  logic                    txFull_q, txReady_q, miso_q, busy_q, rxValid_q, txUnderrun_q;

  logic                    sclkNow, csNow, mosiNow;
  logic                    sclkRise, sclkFall, leadEdge, trailEdge, sampleEdge, shiftEdge;
  logic                    csFall, csRise, frameStart, inFrame, sampleEv, shiftEv;
  logic                    wordLoad, bufLoad, consume, txFull_d;
  logic [DATA_WIDTH-1:0]   txShift_d, rxShift_d;

  // Synchronizers idle at the bus-idle levels so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclkSync_q <= {SYNC_STAGES{SclkIdle}};
      csSync_q   <= '1;
      mosiSync_q <= '0;
      sclkPrev_q <= SclkIdle;
      csPrev_q   <= 1'b1;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk};
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], cs};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi};
      sclkPrev_q <= sclkSync_q[SYNC_STAGES-1];
      csPrev_q   <= csSync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sclkNow    = sclkSync_q[SYNC_STAGES-1];
    csNow      = csSync_q[SYNC_STAGES-1];
    mosiNow    = mosiSync_q[SYNC_STAGES-1];
    sclkRise   = sclkNow & ~sclkPrev_q;
    sclkFall   = ~sclkNow & sclkPrev_q;
    leadEdge   = SclkIdle ? sclkFall : sclkRise;
    trailEdge  = SclkIdle ? sclkRise : sclkFall;
    sampleEdge = (CPHA == 0) ? leadEdge : trailEdge;
    shiftEdge  = (CPHA == 0) ? trailEdge : leadEdge;
    csFall     = csPrev_q & ~csNow;
    csRise     = ~csPrev_q & csNow;
    // A cs fall is handled first, so an sclk edge in the same cycle already counts as in-frame.
    frameStart = (state_q == IDLE) && csFall;
    inFrame    = frameStart || ((state_q == ACTIVE) && !csRise);
    sampleEv   = inFrame && sampleEdge;
    shiftEv    = inFrame && shiftEdge;
    wordLoad   = (shiftEv && (bitCnt_q == '0)) || ((CPHA == 0) && frameStart);
    bufLoad    = tx_valid && txReady_q;
    consume    = wordLoad && txFull_q;
    txFull_d   = bufLoad || (txFull_q && !consume);
    txShift_d  = txShift_q;
    if (wordLoad)
      txShift_d = txFull_q ? txBuf_q : '0;
    else if (shiftEv)
      txShift_d = {txShift_q[DATA_WIDTH-2:0], 1'b0};
    rxShift_d  = {rxShift_q[DATA_WIDTH-2:0], mosiNow};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      txBuf_q      <= '0;
      txShift_q    <= '0;
      rxShift_q    <= '0;
      rxData_q     <= '0;
      txFull_q     <= 1'b0;
      txReady_q    <= 1'b0;
      miso_q       <= 1'b0;
      busy_q       <= 1'b0;
      rxValid_q    <= 1'b0;
      txUnderrun_q <= 1'b0;
    end else begin
      rxValid_q    <= 1'b0;
      txUnderrun_q <= wordLoad && !txFull_q;
      txFull_q     <= txFull_d;
      txReady_q    <= !txFull_d;
      if (bufLoad)
        txBuf_q <= tx_data;
      txShift_q <= txShift_d;
      miso_q    <= inFrame && txShift_d[DATA_WIDTH-1];
      if (sampleEv) begin
        rxShift_q <= rxShift_d;
        if (bitCnt_q == LastBit) begin
          rxData_q  <= rxShift_d;
          rxValid_q <= 1'b1;
          bitCnt_q  <= '0;
        end else begin
          bitCnt_q <= bitCnt_q + 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          if (csFall) begin
            state_q <= ACTIVE;
            busy_q  <= 1'b1;
          end
        end
        ACTIVE: begin
          // Partial words are dropped by rewinding the bit counter.
          if (csRise) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            bitCnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = busy_q;
  assign busy        = busy_q;
  assign tx_ready    = txReady_q;
  assign rx_data     = rxData_q;
  assign rx_valid    = rxValid_q;
  assign tx_underrun = txUnderrun_q;

endmodule
